lsu: RTL
========

Name: lsu

Overview:
- Load/store unit: the initiator side of the data-memory port.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the data memory's address, write data, format, read-enable and write-enable lines, captures the memory's combinational read data, and returns one response per request.
- Misaligned accesses are split into sequential byte accesses. Out-of-range addresses and illegal formats are rejected without touching memory.

Parameters:
- MEM_SIZE, 1024: data memory size in bytes. An access with addr + nbytes > MEM_SIZE is out of range.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  unit can accept a request (high only in IDLE).
- i_req_we  input  1  1 = store, 0 = load.
- i_req_fmt  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr  input  32  byte address.
- i_req_wdata  input  32  store data; low bytes used.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rsp_rdata  output  32  load result, extended per fmt; 0 for stores and errors.
- o_rsp_err  output  1  request rejected; qualified by o_rsp_valid.
- o_mem_addr  output  32  memory byte address.
- o_mem_w_data  output  32  memory write data.
- o_mem_fmt  output  3  memory access format.
- o_mem_r_en  output  1  memory read enable.
- o_mem_w_en  output  1  memory write enable; memory writes on the rising edge.
- i_mem_r_data  input  32  memory read data, valid in the same cycle as the address.

Behaviour:
- Reset: state = IDLE. Outputs after reset: o_req_ready=1; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0; all o_mem_* = 0.
- Reset mid-operation returns to IDLE immediately and drops the request with no response. Bytes already written by a split store stay written; there is no rollback.
- Request acceptance: a request is accepted on a rising edge when i_req_valid && o_req_ready. On acceptance the unit latches we, fmt, addr and wdata.
- Legality (nbytes = 1/2/4 for fmt[1:0] = 00/01/10):
  - Illegal: fmt in {011, 110, 111}.
  - Illegal: store with fmt[2] = 1.
  - Illegal: out of range, checked in 33-bit arithmetic so there is no wrap.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
- States and transitions:
  - IDLE: o_mem_* = 0.
    - Accept legal aligned -> ACCESS.
    - Accept legal misaligned -> SPLIT, with cnt = 0.
    - Accept illegal -> RESP with err = 1.
  - ACCESS, one cycle:
    - o_mem_addr = addr, o_mem_fmt = fmt; r_en = !we, w_en = we; o_mem_w_data = wdata.
    - Loads capture i_mem_r_data at the edge; the memory itself performs the extension.
    - Next state: RESP.
  - SPLIT, nbytes cycles:
    - Byte k = cnt; o_mem_addr = addr + k.
    - Load: fmt = 100, r_en = 1, i_mem_r_data[7:0] is captured into result byte k.
    - Store: fmt = 000, w_en = 1, o_mem_w_data = {24'b0, wdata[8k+:8]}.
    - cnt increments each cycle. After byte nbytes-1, the assembled value is sign-extended (B/H) or zero-extended (BU/HU) and the state moves to RESP.
  - RESP, one cycle:
    - o_rsp_valid = 1; rdata/err driven; o_req_ready = 0. No backpressure.
    - Next state: IDLE.
- Latency from the acceptance edge to the o_rsp_valid cycle:
  - Aligned: 2 cycles.
  - Split: nbytes + 1 cycles.
  - Illegal: 1 cycle.
- Throughput: a new request can be accepted in the cycle after RESP.
- o_mem_w_en is never asserted for illegal requests or outside ACCESS/SPLIT.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access is illegal. It goes straight to RESP with err = 1 and rdata = 0, with no memory cycles. The SPLIT state and cnt are not built.
- Undefined: misaligned accesses are split as described in Behaviour.

Decomposition:
- Package lsu_pkg holds:
  - format localparams FMT_B=3'b000, FMT_H=3'b001, FMT_W=3'b010, FMT_BU=3'b100, FMT_HU=3'b101;
  - state enum {IDLE, ACCESS, SPLIT, RESP};
  - function fmt_nbytes(fmt).
- One sub-module, lsu_extend: combinational sign/zero extension of the assembled split-load data per fmt.

Test Plan:
- Aligned SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp at +2 cycles with err=0 and rdata=0; load rdata=0xDEADBEEF; mem w_en high for exactly 1 cycle.
- Memory 0x20..0x23 = 80 FF 01 02. LB @0x20 -> 0xFFFFFF80. LBU @0x20 -> 0x00000080. LH @0x20 -> 0xFFFFFF80. LHU @0x22 -> 0x00000201.
- Misaligned LW @0x21 with 0x21..0x24 = 11 22 33 44 -> 4 byte reads at 0x21..0x24, rsp at +5 cycles, rdata=0x44332211. With LSU_MISALIGN_TRAP_EN: err=1 at +1 cycle, no r_en pulses.
- Misaligned SH 0xABCD @0x31 -> bytes 0x31=CD and 0x32=AB written; subsequent LHU @0x31 -> 0x0000ABCD.
- Illegal and out-of-range: fmt=011 load; SB with fmt=100; LW @1022 (MEM_SIZE=1024) -> each gives err=1, rdata=0 at +1 cycle, no memory enables.
- Reset during SPLIT of SW 0x11223344 @0x41 after 2 bytes -> next cycle IDLE, all outputs 0, no rsp; bytes 0x41=44 and 0x42=33 remain written.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared formats, FSM state type and size helper for the load/store unit
package lsu_pkg;

    // funct3 access formats
    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } state_t;

    // Bytes touched by an access; illegal formats report 4 and are rejected elsewhere.
    function automatic logic [2:0] fmt_nbytes(input logic [2:0] fmt);
        case (fmt)
            FMT_B, FMT_BU: fmt_nbytes = 3'd1;
            FMT_H, FMT_HU: fmt_nbytes = 3'd2;
            default:       fmt_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of an assembled load value
//
// Ports:
//   fmt  in  3   access format (B/H sign-extend, BU/HU zero-extend, W pass-through)
//   data in  32  assembled little-endian load bytes
//   ext  out 32  extended result
module lsu_extend (
    input  logic [2:0]  fmt,
    input  logic [31:0] data,
    output logic [31:0] ext
);
    import lsu_pkg::*;

    always_comb begin
        ext = data;
        case (fmt)
            FMT_B:   ext = {{24{data[7]}}, data[7:0]};
            FMT_H:   ext = {{16{data[15]}}, data[15:0]};
            FMT_BU:  ext = {24'h0, data[7:0]};
            FMT_HU:  ext = {16'h0, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit, initiator side of the data-memory port
//
// One request at a time over i_req_valid/o_req_ready; one o_rsp_valid pulse per request.
// Aligned accesses take one memory cycle, misaligned ones are split into byte accesses,
// illegal/out-of-range requests are rejected without memory traffic.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid/o_req_ready      request handshake; i_req_we, i_req_fmt, i_req_addr, i_req_wdata
//   o_rsp_valid/rdata/err        response pulse, load data, reject flag
//   o_mem_addr/w_data/fmt/r_en/w_en, i_mem_r_data   data-memory port (combinational read)
//
// Build option: LSU_MISALIGN_TRAP_EN - reject misaligned accesses instead of splitting them.
module lsu #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_fmt,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_w_data,
    output logic [2:0]  o_mem_fmt,
    output logic        o_mem_r_en,
    output logic        o_mem_w_en,
    input  logic [31:0] i_mem_r_data
);
    import lsu_pkg::*;

    state_t      state;
    logic        we_q;
    logic [2:0]  fmt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Classification of the incoming request
    logic [2:0]  req_nbytes;
    logic [32:0] req_end;
    logic        bad_fmt;
    logic        bad_store;
    logic        out_of_range;
    logic        misaligned;
    logic        illegal;

    always_comb begin
        req_nbytes   = fmt_nbytes(i_req_fmt);
        // 33-bit sum so an address near 2^32 cannot wrap into range
        req_end      = {1'b0, i_req_addr} + {30'h0, req_nbytes};
        bad_fmt      = (i_req_fmt[1:0] == 2'b11) || (i_req_fmt == 3'b110);
        bad_store    = i_req_we && i_req_fmt[2];
        out_of_range = req_end > 33'(MEM_SIZE);
        misaligned   = ((i_req_fmt[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_fmt[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        illegal      = bad_fmt || bad_store || out_of_range || misaligned;
`else
        illegal      = bad_fmt || bad_store || out_of_range;
`endif
    end

`ifndef LSU_MISALIGN_TRAP_EN
    logic [1:0]  cnt;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [31:0] asm_ext;
    logic        split_last;

    // asm_next includes the byte arriving this cycle so the final value can be
    // extended and registered on the last byte's edge without an extra cycle.
    always_comb begin
        asm_next                     = asm_q;
        asm_next[{cnt, 3'b000} +: 8] = i_mem_r_data[7:0];
        split_last                   = ({1'b0, cnt} + 3'd1) == fmt_nbytes(fmt_q);
    end

    lsu_extend u_extend (
        .fmt  (fmt_q),
        .data (asm_next),
        .ext  (asm_ext)
    );
`endif

    // Memory port and response decode from registered state
    always_comb begin
        o_mem_addr   = 32'h0;
        o_mem_w_data = 32'h0;
        o_mem_fmt    = 3'b000;
        o_mem_r_en   = 1'b0;
        o_mem_w_en   = 1'b0;
        case (state)
            ACCESS: begin
                o_mem_addr   = addr_q;
                o_mem_fmt    = fmt_q;
                o_mem_r_en   = !we_q;
                o_mem_w_en   = we_q;
                o_mem_w_data = wdata_q;
            end
`ifndef LSU_MISALIGN_TRAP_EN
            SPLIT: begin
                o_mem_addr   = addr_q + {30'h0, cnt};
                o_mem_fmt    = we_q ? FMT_B : FMT_BU;
                o_mem_r_en   = !we_q;
                o_mem_w_en   = we_q;
                o_mem_w_data = {24'h0, wdata_q[{cnt, 3'b000} +: 8]};
            end
`endif
            default: ;
        endcase
    end

    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
    assign o_rsp_err   = (state == RESP) ? err_q : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            fmt_q   <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
            cnt     <= 2'd0;
            asm_q   <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q    <= i_req_we;
                        fmt_q   <= i_req_fmt;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                        if (illegal) begin
                            err_q <= 1'b1;
                            state <= RESP;
`ifndef LSU_MISALIGN_TRAP_EN
                        end else if (misaligned) begin
                            cnt   <= 2'd0;
                            asm_q <= 32'h0;
                            state <= SPLIT;
`endif
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // memory already extended the value per fmt
                    if (!we_q) rdata_q <= i_mem_r_data;
                    state <= RESP;
                end
`ifndef LSU_MISALIGN_TRAP_EN
                SPLIT: begin
                    if (!we_q) asm_q <= asm_next;
                    cnt <= cnt + 2'd1;
                    if (split_last) begin
                        if (!we_q) rdata_q <= asm_ext;
                        state <= RESP;
                    end
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
